// File: rtl/osc_step_sequencer.sv
// rtl/osc_step_sequencer.sv - eight-step pitch/gate pattern sequencer driving one oscillator
module osc_step_sequencer #(
  parameter int unsigned TOP_W    = 17,
  parameter int unsigned TICK_DIV = 750000,
  parameter int unsigned GATE_LEN = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_addr,
  input  logic [TOP_W-1:0] wr_pitch,
  input  logic             wr_gate,
  output logic [TOP_W-1:0] counter_top,
  output logic             osc_rst,
  output logic [2:0]       step,
  output logic             step_strobe,
  output logic             gate
);

  localparam int unsigned       TICK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [2:0]         step_q, step_d;
  logic [TOP_W-1:0]   counter_top_q, counter_top_d;
  logic               step_strobe_q, step_strobe_d;
  logic               gate_q, gate_d;
  logic               osc_rst_q, osc_rst_d;
  // gate enable AND pitch-nonzero of the playing step, frozen at its load
  logic               voiced_q, voiced_d;
  logic [TOP_W-1:0]   pitch_q [8];
  logic [TOP_W-1:0]   pitch_d [8];
  logic [7:0]         gate_en_q, gate_en_d;

  logic               load;
  logic [2:0]         load_step;
  logic               wr_fire;

  function automatic logic in_gate_window(input logic [TICK_W-1:0] t);
    return 32'(t) < GATE_LEN;
  endfunction

  // A write is refused only on cycles whose edge loads a step, so a load never races a write.
  assign wr_ready = rst | ~load;
  assign wr_fire  = wr_valid & wr_ready;

  // Next-state: IDLE/PLAY control, tick/step advance, step load and gate window.
  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    step_d        = step_q;
    counter_top_d = counter_top_q;
    step_strobe_d = 1'b0;
    voiced_d      = voiced_q;
    gate_d        = 1'b0;
    osc_rst_d     = 1'b1;
    load          = 1'b0;
    load_step     = 3'(step_q + 3'd1);

    case (state_q)
      IDLE: begin
        tick_d = '0;
        step_d = 3'd0;
        if (run) begin
          load      = 1'b1;
          load_step = 3'd0;
        end
      end
      PLAY: begin
        if (!run) begin
          // stopping wins over a step advance in the same cycle
          state_d = IDLE;
          tick_d  = '0;
          step_d  = 3'd0;
        end else if (tick_q == TICK_LAST) begin
          load = 1'b1;
        end else begin
          tick_d = tick_q + TICK_W'(1);
          gate_d = voiced_q & in_gate_window(tick_d);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d       = PLAY;
      step_d        = load_step;
      tick_d        = '0;
      counter_top_d = pitch_q[load_step];
      step_strobe_d = 1'b1;
      voiced_d      = gate_en_q[load_step] & (|pitch_q[load_step]);
      gate_d        = voiced_d & in_gate_window('0);
    end

    osc_rst_d = ~gate_d;
  end

  // Pattern storage update from an accepted write.
  always_comb begin
    pitch_d   = pitch_q;
    gate_en_d = gate_en_q;
    if (wr_fire) begin
      pitch_d[wr_addr]   = wr_pitch;
      gate_en_d[wr_addr] = wr_gate;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      step_q        <= 3'd0;
      counter_top_q <= '0;
      step_strobe_q <= 1'b0;
      gate_q        <= 1'b0;
      osc_rst_q     <= 1'b1;
      voiced_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      step_q        <= step_d;
      counter_top_q <= counter_top_d;
      step_strobe_q <= step_strobe_d;
      gate_q        <= gate_d;
      osc_rst_q     <= osc_rst_d;
      voiced_q      <= voiced_d;
    end
  end

  // Pattern registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        pitch_q[i] <= '0;
      end
      gate_en_q <= '0;
    end else begin
      pitch_q   <= pitch_d;
      gate_en_q <= gate_en_d;
    end
  end

  assign counter_top = counter_top_q;
  assign osc_rst     = osc_rst_q;
  assign step        = step_q;
  assign step_strobe = step_strobe_q;
  assign gate        = gate_q;

endmodule

// File: tb/tb_osc_step_sequencer.sv
// tb/tb_osc_step_sequencer.sv - directed plus random check of osc_step_sequencer against a pattern model
module tb_osc_step_sequencer;

  localparam int TW = 17;
  localparam int TD = 8;

  logic          clk;
  logic          rst;
  logic          run;
  logic          wr_valid;
  logic [2:0]    wr_addr;
  logic [TW-1:0] wr_pitch;
  logic          wr_gate;

  logic          wr_ready, osc_rst, step_strobe, gate;
  logic [TW-1:0] counter_top;
  logic [2:0]    step;

  logic          wr_ready_0, osc_rst_0, step_strobe_0, gate_0;
  logic [TW-1:0] counter_top_0;
  logic [2:0]    step_0;

  logic          wr_ready_8, osc_rst_8, step_strobe_8, gate_8;
  logic [TW-1:0] counter_top_8;
  logic [2:0]    step_8;

  osc_step_sequencer #(.TOP_W(TW), .TICK_DIV(TD), .GATE_LEN(5)) dut (
    .clk(clk), .rst(rst), .run(run), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_pitch(wr_pitch), .wr_gate(wr_gate),
    .counter_top(counter_top), .osc_rst(osc_rst), .step(step),
    .step_strobe(step_strobe), .gate(gate)
  );

  osc_step_sequencer #(.TOP_W(TW), .TICK_DIV(TD), .GATE_LEN(0)) dut_g0 (
    .clk(clk), .rst(rst), .run(run), .wr_valid(wr_valid), .wr_ready(wr_ready_0),
    .wr_addr(wr_addr), .wr_pitch(wr_pitch), .wr_gate(wr_gate),
    .counter_top(counter_top_0), .osc_rst(osc_rst_0), .step(step_0),
    .step_strobe(step_strobe_0), .gate(gate_0)
  );

  osc_step_sequencer #(.TOP_W(TW), .TICK_DIV(TD), .GATE_LEN(8)) dut_g8 (
    .clk(clk), .rst(rst), .run(run), .wr_valid(wr_valid), .wr_ready(wr_ready_8),
    .wr_addr(wr_addr), .wr_pitch(wr_pitch), .wr_gate(wr_gate),
    .counter_top(counter_top_8), .osc_rst(osc_rst_8), .step(step_8),
    .step_strobe(step_strobe_8), .gate(gate_8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: pattern, play flag, cycles since the run started, snapshot of the loaded step
  logic [TW-1:0] m_pitch [8];
  bit            m_gen   [8];
  bit            m_play;
  int            m_c;
  logic [TW-1:0] s_pitch;
  bit            s_gen;
  bit            m_acc;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_pitch[i] = '0;
      m_gen[i]   = 1'b0;
    end
    m_play  = 1'b0;
    m_c     = 0;
    s_pitch = '0;
    s_gen   = 1'b0;
    m_acc   = 1'b0;
  endtask

  task automatic model_load(input int k);
    s_pitch = m_pitch[k];
    s_gen   = m_gen[k];
  endtask

  task automatic model_edge();
    bit rdy;
    m_acc = 1'b0;
    if (rst) begin
      model_clear();
      return;
    end
    rdy = !(run && (!m_play || (m_c % TD) == TD - 1));
    if (!run) begin
      m_play = 1'b0;
      m_c    = 0;
    end else if (!m_play) begin
      m_play = 1'b1;
      m_c    = 0;
      model_load(0);
    end else begin
      m_c++;
      if ((m_c % TD) == 0) model_load((m_c / TD) % 8);
    end
    if (wr_valid && rdy) begin
      m_pitch[wr_addr] = wr_pitch;
      m_gen[wr_addr]   = wr_gate;
      m_acc            = 1'b1;
    end
  endtask

  function automatic logic exp_gate(input int gl);
    return m_play && s_gen && (s_pitch != 0) && ((m_c % TD) < gl);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_step;
    logic [31:0] e_rdy;
    e_step = m_play ? 32'((m_c / TD) % 8) : 32'd0;
    e_rdy  = rst ? 32'd1 : 32'(!(run && (!m_play || (m_c % TD) == TD - 1)));
    chk("counter_top", 32'(counter_top), 32'(s_pitch));
    chk("step", 32'(step), e_step);
    chk("step_strobe", 32'(step_strobe), 32'(m_play && (m_c % TD) == 0));
    chk("gate", 32'(gate), 32'(exp_gate(5)));
    chk("osc_rst", 32'(osc_rst), 32'(!exp_gate(5)));
    chk("wr_ready", 32'(wr_ready), e_rdy);
    chk("gate_len0", 32'(gate_0), 32'd0);
    chk("osc_rst_len0", 32'(osc_rst_0), 32'd1);
    chk("gate_len8", 32'(gate_8), 32'(exp_gate(8)));
    chk("osc_rst_len8", 32'(osc_rst_8), 32'(!exp_gate(8)));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [TW-1:0] p, input logic g);
    bit done;
    done     = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_pitch = p;
    wr_gate  = g;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc();
      done = m_acc;
    end
    chk("write_timeout", 32'(done), 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic wait_pos(input int stp, input int tk);
    bit hit;
    hit = m_play && ((m_c / TD) % 8) == stp && (m_c % TD) == tk;
    for (int i = 0; i < 400 && !hit; i++) begin
      cyc();
      hit = m_play && ((m_c / TD) % 8) == stp && (m_c % TD) == tk;
    end
    chk("align_timeout", 32'(hit), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    run      = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 3'd0;
    wr_pitch = '0;
    wr_gate  = 1'b0;
    model_clear();

    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // full pattern of rising pitches, all gated
    for (int k = 0; k < 8; k++) begin
      do_write(3'(k), TW'(32'h200 * (k + 1)), 1'b1);
    end
    run = 1'b1;
    repeat (140) cyc();

    // rests: zero pitch with gate on, nonzero pitch with gate off
    do_write(3'd3, '0, 1'b1);
    do_write(3'd5, TW'(32'h800), 1'b0);
    repeat (80) cyc();

    // write held across a step boundary
    wait_pos(0, 7);
    do_write(3'd2, TW'(32'h1234), 1'b1);
    repeat (20) cyc();

    // write to the step currently playing
    wait_pos(2, 2);
    do_write(3'd2, TW'(32'h0777), 1'b0);
    repeat (70) cyc();

    // stop on the last tick of step 4, then restart
    wait_pos(4, 7);
    run = 1'b0;
    cyc();
    cyc();
    run = 1'b1;
    repeat (20) cyc();

    // asynchronous reset in the middle of a step
    repeat (3) cyc();
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check_all();
    cyc();
    cyc();
    rst = 1'b0;
    repeat (70) cyc();

    // random pattern writes and run toggles
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if (!wr_valid || m_acc) begin
        wr_valid = ($urandom_range(0, 5) == 0);
        wr_addr  = 3'($urandom_range(0, 7));
        wr_pitch = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom);
        wr_gate  = 1'($urandom_range(0, 1));
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/osc_step_sequencer.md
# osc_step_sequencer

Eight-step pattern sequencer that owns the oscillator's `counter_top` and `rst` inputs: it stores one pitch word and one gate-enable bit per step, advances through the steps at a fixed tempo, and gates the oscillator on and off within each step. Sits between the button/LED front-end, which writes the pattern and drives `run`, and the single oscillator instance that drives `pwmout`.

## Interface
- `TOP_W`, 17: width of the pitch word and of `counter_top`.
- `TICK_DIV`, 750000: clocks per step, must be ≥ 2.
- `GATE_LEN`, 500000: clocks per step with the gate high; 0 means never, ≥ `TICK_DIV` means continuous.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `run`  in  1  level; 1 = play, 0 = stop.
- `wr_valid`  in  1  pattern write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready` at a rising edge.
- `wr_addr`  in  3  step index, 0..7.
- `wr_pitch`  in  TOP_W  pitch word for the step; 0 = rest.
- `wr_gate`  in  1  step gate enable.
- `counter_top`  out  TOP_W  to the oscillator `counter_top`.
- `osc_rst`  out  1  to the oscillator `rst`; 1 = silent.
- `step`  out  3  index of the step now playing.
- `step_strobe`  out  1  one-cycle pulse on the first cycle of every step.
- `gate`  out  1  gate state, for LEDs.

## Operation
- Storage: 8 × (TOP_W + 1) registers. `rst` clears all pitch words and gate bits to 0.
- States: IDLE and PLAY.
- IDLE:
  - `osc_rst` = 1, `gate` = 0, `step` = 0, tick counter = 0.
  - `counter_top` holds its last value.
  - When `run` = 1: go to PLAY and load step 0.
- Load of step k: `step` ← k, `counter_top` ← pitch[k], tick ← 0, `step_strobe` = 1 for that one cycle.
- PLAY:
  - Tick counts 0..TICK_DIV-1.
  - At tick = TICK_DIV-1: load step (step+1) mod 8, so 7 wraps to 0.
  - `gate` = gate_en[step] && pitch[step] != 0 && tick < GATE_LEN. A zero pitch is always a rest.
  - `osc_rst` = ~`gate`.
- `run` = 0 in PLAY: go to IDLE at the next edge. This takes priority over a step advance in the same cycle. The sequence restarts from step 0 on the next `run` = 1.
- Write handshake:
  - `wr_ready` = 0 in any cycle whose following edge performs a load. That is IDLE with `run` = 1, or PLAY with `run` = 1 and tick = TICK_DIV-1. Otherwise `wr_ready` = 1.
  - An accepted write updates storage at that edge.
  - Writes are never lost. A held `wr_valid` completes on the next ready cycle.
- A write to the currently playing step does not change `counter_top` or `gate` until that step is next loaded. Gate uses a latched copy of the step's gate and pitch-nonzero bits, taken at load.

## Timing
- All outputs are registered. Reset values: `counter_top` = 0, `osc_rst` = 1, `step` = 0, `step_strobe` = 0, `gate` = 0, `wr_ready` = 1, state = IDLE, tick = 0.
- `rst` asserted mid-operation:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - The pattern is cleared.
- Start: `run` rises in cycle n. In cycle n+1: state PLAY, `step` = 0, `step_strobe` = 1, `counter_top` = pitch[0], `gate`/`osc_rst` valid.
- Each step lasts exactly TICK_DIV cycles. A full pattern is 8·TICK_DIV cycles.
- Gate: high for cycles 0..GATE_LEN-1 of the step, measured from the strobe cycle.
- Stop: `run` falls in cycle m. In cycle m+1: IDLE, `osc_rst` = 1, `gate` = 0, `step` = 0.
- Write latency: accepted at edge e; visible to any load at edge e+1 or later.

## Test plan
Bench parameters: TOP_W=17, TICK_DIV=8, GATE_LEN=5.
- Reset check: assert `rst` asynchronously mid-PLAY. Outputs immediately take their reset values; after release with `run` = 1, every pitch word reads back as 0 via `counter_top`, and `gate` stays 0.
- Full pattern: write pitch[k] = 0x200·(k+1), gate 1, for all k, then raise `run`.
  - `step_strobe` pulses every 8 cycles.
  - `counter_top` steps 0x200, 0x400, …, 0x1000, then wraps to 0x200.
  - `gate` is high for 5 of every 8 cycles; `osc_rst` = ~`gate`.
- Rests: pitch[3] = 0 with gate 1, and pitch[5] = 0x800 with gate 0. `gate` stays 0 for all 8 cycles of steps 3 and 5.
- Handshake: hold `wr_valid` (addr 2, pitch 0x1234) across a step boundary.
  - `wr_ready` is 0 only in the tick=7 cycle; the write completes the cycle after.
  - A write to the playing step changes `counter_top` only on its next visit, 64 cycles later.
- Stop/restart: drop `run` at tick 7 of step 4. Next cycle is IDLE with `step` = 0 and `osc_rst` = 1, with no step-5 load. Raising `run` again restarts at step 0 with a strobe.
- Edge parameters: GATE_LEN=0 gives `gate` constantly 0; GATE_LEN=8 gives `gate` continuously 1 across enabled, nonzero steps.
